mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between instruction fetch and the MEM stage, with data given priority.
// Build macro MEM_ARB_TIMEOUT_EN adds a request timeout that drives err.
// Ports: clk, rst_n (async, active-low); if_req/if_addr -> if_done;
//   dm_read/dm_write/dm_addr/dm_wdata/dm_wstrb -> dm_done;
//   rdata, busy, err; memory side mem_req/we/addr/wdata/wstrb,
//   mem_rdata/mem_ack.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TO_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [3:0]        dm_wstrb,
   output logic              dm_done,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   if (DATA_W != 32 || TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_cfg
      $error("mem_port_arbiter: DATA_W must be 32, TO_CYCLES 2..255");
   end

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic              busy_q, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
   // Timeout fires when the counter would reach TO_CYCLES-1 without ack.
   localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 2);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rdata_d     = rdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
            if (dm_read || dm_write) begin
               // A simultaneous read+write is handled as a write.
               state_d     = S_DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_write;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               mem_wstrb_d = dm_write ? dm_wstrb : 4'b0000;
            end else if (if_req) begin
               state_d     = S_FETCH;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wstrb_d = 4'b0000;
            end
         end
         S_DATA, S_FETCH: begin
            if (mem_ack) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               if (!mem_we_q) rdata_d = mem_rdata;
               dm_done_d = (state_q == S_DATA);
               if_done_d = (state_q == S_FETCH);
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               rdata_d   = '0;
               dm_done_d = (state_q == S_DATA);
               if_done_d = (state_q == S_FETCH);
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         rdata_q     <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rdata_q     <= rdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         busy_q      <= busy_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign rdata     = rdata_q;
   assign if_done   = if_done_q;
   assign dm_done   = dm_done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_done;
   logic [31:0] rdata;
   logic        busy;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_chk  = 0;
   int n_fail = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TO_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_done(dm_done),
      .rdata(rdata), .busy(busy), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0;
      if_req = 0; if_addr = 0;
      dm_read = 0; dm_write = 0; dm_addr = 0;
      dm_wdata = 0; dm_wstrb = 0;
      mem_rdata = 0; mem_ack = 0;
      #12;
      check("rst mem_req", mem_req, 0);
      check("rst busy", busy, 0);
      check("rst rdata", rdata, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst wstrb", mem_wstrb, 0);
      check("rst done", {if_done, dm_done, err}, 0);
      rst_n = 1'b1;
      tick();

      // single load, ack in cycle 3
      dm_read = 1; dm_addr = 32'h100;
      tick();
      check("ld mem_req c1", mem_req, 1);
      check("ld mem_we", mem_we, 0);
      check("ld mem_addr", mem_addr, 32'h100);
      check("ld wstrb", mem_wstrb, 0);
      check("ld busy", busy, 1);
      tick();
      check("ld mem_req c2", mem_req, 1);
      tick();
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      check("ld no early done", dm_done, 0);
      tick();
      mem_ack = 0; dm_read = 0; mem_rdata = 32'h0;
      check("ld dm_done", dm_done, 1);
      check("ld if_done", if_done, 0);
      check("ld rdata", rdata, 32'hDEADBEEF);
      check("ld mem_req off", mem_req, 0);
      check("ld err", err, 0);
      tick();
      check("ld done pulse", dm_done, 0);
      check("ld idle", busy, 0);

      // store, ack held low for five cycles
      dm_write = 1; dm_addr = 32'h300;
      dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
      ok = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!(mem_req && mem_we && mem_wstrb == 4'b0011 &&
               mem_wdata == 32'h12345678 && mem_addr == 32'h300))
            ok = 0;
      end
      check("st stable", 32'(ok), 1);
      mem_ack = 1; mem_rdata = 32'h55555555;
      tick();
      mem_ack = 0; dm_write = 0;
      check("st dm_done", dm_done, 1);
      check("st rdata kept", rdata, 32'hDEADBEEF);
      tick();
      check("st idle", busy, 0);

      // contention: data first, ack held high throughout
      mem_ack = 1; mem_rdata = 32'hA5A50200;
      if_req = 1; if_addr = 32'h40;
      dm_read = 1; dm_addr = 32'h200;
      tick();
      check("ct c1 addr", mem_addr, 32'h200);
      tick();
      dm_read = 0; mem_rdata = 32'h5A5A0040;
      check("ct c2 dm_done", dm_done, 1);
      check("ct c2 if_done", if_done, 0);
      check("ct c2 rdata", rdata, 32'hA5A50200);
      tick();
      check("ct c3 idle", busy, 0);
      tick();
      check("ct c4 addr", mem_addr, 32'h40);
      check("ct c4 req", mem_req, 1);
      tick();
      if_req = 0; mem_ack = 0;
      check("ct c5 if_done", if_done, 1);
      check("ct c5 rdata", rdata, 32'h5A5A0040);
      tick();

      // reset while a fetch is in flight
      if_req = 1; if_addr = 32'h80;
      tick();
      check("rm req before", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rm req async", mem_req, 0);
      check("rm busy async", busy, 0);
      check("rm rdata async", rdata, 0);
      tick();
      check("rm no done", {if_done, dm_done}, 0);
      rst_n = 1'b1;
      tick();
      check("rm refetch req", mem_req, 1);
      check("rm refetch addr", mem_addr, 32'h80);
      mem_ack = 1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_ack = 0; if_req = 0;
      check("rm refetch done", if_done, 1);
      check("rm refetch rdata", rdata, 32'h0BADF00D);
      tick();

      // fetch that never gets an ack
      if_req = 1; if_addr = 32'hC0;
`ifdef MEM_ARB_TIMEOUT_EN
      ok = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (!mem_req) ok = 0;
      end
      check("to req 3 cycles", 32'(ok), 1);
      tick();
      if_req = 0;
      check("to req drop", mem_req, 0);
      check("to if_done", if_done, 1);
      check("to err", err, 1);
      check("to rdata", rdata, 0);
      tick();
      check("to err pulse", err, 0);
`else
      ok = 1;
      for (int i = 0; i < 105; i++) begin
         tick();
         if (!mem_req || err || if_done) ok = 0;
      end
      check("noto req held", 32'(ok), 1);
      mem_ack = 1; mem_rdata = 32'h00C0FFEE;
      tick();
      mem_ack = 0; if_req = 0;
      check("noto if_done", if_done, 1);
      check("noto rdata", rdata, 32'h00C0FFEE);
      tick();
`endif
      tick();

      // read and write both high -> one write
      dm_read = 1; dm_write = 1; dm_addr = 32'h400;
      dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'b1111;
      tick();
      check("rw mem_we", mem_we, 1);
      check("rw wstrb", mem_wstrb, 4'b1111);
      mem_ack = 1; mem_rdata = 32'h11111111;
      tick();
      mem_ack = 0; dm_read = 0; dm_write = 0;
      check("rw dm_done", dm_done, 1);
      check("rw if_done", if_done, 0);
      tick();
      check("rw single done", dm_done, 0);
      tick();
      check("rw stays idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
